// File: rtl/crc32_pkg.sv
// Shared CRC-32 constants, frame FSM states and keep decoding for the frame accumulator.
package crc32_pkg;

  localparam int unsigned CRC_W  = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned KEEP_W = 4;

  localparam logic [CRC_W-1:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] CRC32_XOROUT    = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [CRC_W-1:0] CRC32_POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_TAIL  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Byte count for contiguous low-aligned keep; 0 flags an illegal pattern.
  function automatic logic [2:0] keep_bytes(input logic [KEEP_W-1:0] keep);
    logic [2:0] n;
    case (keep)
      4'b0001: n = 3'd1;
      4'b0011: n = 3'd2;
      4'b0111: n = 3'd3;
      4'b1111: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational reflected CRC-32 step over a single byte (8 unrolled shift/XOR stages).
module crc32_byte_step
  import crc32_pkg::*;
(
  input  logic [CRC_W-1:0]  crc_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic [CRC_W-1:0]  crc_o
);

  always_comb begin
    logic [CRC_W-1:0] v;
    v = crc_i ^ {24'd0, data_i};
    for (int i = 0; i < 8; i++) begin
      v = v[0] ? ((v >> 1) ^ CRC32_POLY_REFL) : (v >> 1);
    end
    crc_o = v;
  end

endmodule

// File: rtl/crc_calc.sv
// Combinational reflected CRC-32 step over one 32-bit word, byte 0 in bits [7:0] first.
module crc_calc
  import crc32_pkg::*;
(
  input  logic [CRC_W-1:0] crc_i,
  input  logic [CRC_W-1:0] data_i,
  output logic [CRC_W-1:0] crc_o
);

  always_comb begin
    logic [CRC_W-1:0] v;
    v = crc_i ^ data_i;
    for (int i = 0; i < 32; i++) begin
      v = v[0] ? ((v >> 1) ^ CRC32_POLY_REFL) : (v >> 1);
    end
    crc_o = v;
  end

endmodule

// File: rtl/crc32_frame_acc.sv
// Streaming CRC-32 frame accumulator: full words per cycle, 1-3 byte tail per byte,
// then a held FCS / residue verdict on a valid/ready result port.
module crc32_frame_acc
  import crc32_pkg::*;
#(
  parameter logic [31:0] INIT    = CRC32_INIT,
  parameter logic [31:0] XOROUT  = CRC32_XOROUT,
  parameter logic [31:0] RESIDUE = CRC32_RESIDUE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_data_i,
  input  logic [3:0]  s_keep_i,
  input  logic        s_last_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [31:0] m_crc_o,
  output logic        m_good_o,
  output logic        m_err_o
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CRC_W-1:0]  r_crc;
  logic [CRC_W-1:0]  w_crc_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic [CRC_W-1:0]  r_tail_data;
  logic [1:0]        r_tail_cnt;
  logic [1:0]        r_byte_idx;
  logic              w_load_tail;
  logic              r_s_ready;
  logic              r_m_valid;
  logic [CRC_W-1:0]  r_m_crc;
  logic              r_m_good;
  logic              r_m_err;

  logic [2:0]        w_kb;
  logic              w_accept;
  logic              w_res_hs;
  logic [CRC_W-1:0]  w_crc_word;
  logic [CRC_W-1:0]  w_crc_byte;
  logic [BYTE_W-1:0] w_tail_byte;

  assign w_kb        = keep_bytes(s_keep_i);
  assign w_accept    = s_valid_i & r_s_ready & (r_state == ST_ACCUM);
  assign w_res_hs    = r_m_valid & m_ready_i;
  assign w_tail_byte = r_tail_data[{r_byte_idx, 3'b000} +: 8];

  crc_calc u_word_step (
    .crc_i  (r_crc),
    .data_i (s_data_i),
    .crc_o  (w_crc_word)
  );

  crc32_byte_step u_byte_step (
    .crc_i  (r_crc),
    .data_i (w_tail_byte),
    .crc_o  (w_crc_byte)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_ACCUM;
    else       r_state <= w_state_nxt;
  end

  // Next state plus the CRC/err values that the datapath commits this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_err_nxt   = r_err;
    w_load_tail = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept) begin
          if (w_kb == 3'd4) begin
            w_crc_nxt = w_crc_word;
            if (s_last_i) w_state_nxt = ST_DONE;
          end else if (s_last_i) begin
            if (w_kb != 3'd0) begin
              w_load_tail = 1'b1;
              w_state_nxt = ST_TAIL;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_DONE;
            end
          end else begin
            // Malformed mid-frame keep: still fold the whole word, but flag it.
            w_crc_nxt = w_crc_word;
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        w_crc_nxt = w_crc_byte;
        if (r_byte_idx == (r_tail_cnt - 2'd1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (w_res_hs) begin
          w_state_nxt = ST_ACCUM;
          w_crc_nxt   = INIT;
          w_err_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_crc       <= INIT;
      r_err       <= 1'b0;
      r_tail_data <= '0;
      r_tail_cnt  <= '0;
      r_byte_idx  <= '0;
      r_s_ready   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_crc     <= '0;
      r_m_good    <= 1'b0;
      r_m_err     <= 1'b0;
    end else begin
      r_crc     <= w_crc_nxt;
      r_err     <= w_err_nxt;
      r_s_ready <= (w_state_nxt == ST_ACCUM);
      r_m_valid <= (w_state_nxt == ST_DONE);
      if (w_load_tail) begin
        r_tail_data <= s_data_i;
        r_tail_cnt  <= 2'(w_kb);
        r_byte_idx  <= '0;
      end else if (r_state == ST_TAIL) begin
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      // Result registers capture the final register value on DONE entry only.
      if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
        r_m_crc  <= w_crc_nxt ^ XOROUT;
        r_m_good <= (w_crc_nxt == RESIDUE);
        r_m_err  <= w_err_nxt;
      end
    end
  end

  assign s_ready_o = r_s_ready;
  assign m_valid_o = r_m_valid;
  assign m_crc_o   = r_m_crc;
  assign m_good_o  = r_m_good;
  assign m_err_o   = r_m_err;

endmodule

// File: tb/tb_crc32_frame_acc.sv
// Self-checking bench for crc32_frame_acc against a table-driven byte-level CRC-32 model.
module tb_crc32_frame_acc;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] s_data_i = '0;
  logic [3:0]  s_keep_i = '0;
  logic        s_last_i = 1'b0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [31:0] m_crc_o;
  logic        m_good_o;
  logic        m_err_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] crc_tab [256];
  logic [31:0] f_data [$];
  logic [3:0]  f_keep [$];
  int          send_cycles;

  crc32_frame_acc dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .s_keep_i  (s_keep_i),
    .s_last_i  (s_last_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_crc_o   (m_crc_o),
    .m_good_o  (m_good_o),
    .m_err_o   (m_err_o)
  );

  always #5 clk = ~clk;

  function automatic int kcount(input logic [3:0] k);
    case (k)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b0111: return 3;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  // Reference: whole frame flattened to bytes, then standard table-driven CRC-32.
  task automatic ref_frame(output logic [31:0] raw, output logic err, output int tail_n);
    logic [31:0] w;
    logic [7:0]  b;
    int          n;
    raw = 32'hFFFF_FFFF;
    err = 1'b0;
    tail_n = 0;
    for (int i = 0; i < f_data.size(); i++) begin
      w = f_data[i];
      n = kcount(f_keep[i]);
      if (i != f_data.size() - 1) begin
        if (n != 4) err = 1'b1;
        n = 4;
      end else begin
        if (n == 0) err = 1'b1;
        tail_n = (n == 4) ? 0 : n;
      end
      for (int j = 0; j < n; j++) begin
        b = w[8*j +: 8];
        raw = (raw >> 8) ^ crc_tab[int'(raw[7:0] ^ b)];
      end
    end
  endtask

  task automatic send_frame();
    int guard;
    send_cycles = 0;
    for (int i = 0; i < f_data.size(); i++) begin
      s_valid_i = 1'b1;
      s_data_i  = f_data[i];
      s_keep_i  = f_keep[i];
      s_last_i  = (i == f_data.size() - 1);
      guard = 0;
      while (!s_ready_o && guard < 100) begin
        @(negedge clk);
        guard++;
        send_cycles++;
      end
      if (guard >= 100) begin
        n_checks++;
        $display("FAIL send_ready_timeout: s_ready_o stuck at %b, required 1", s_ready_o);
      end
      @(posedge clk);
      @(negedge clk);
      send_cycles++;
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!m_valid_o && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    m_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s_ready_o, m_valid_o, m_good_o, m_err_o} !== 4'b0000)
      $display("FAIL reset_flags: rdy/val/good/err %b required 0000",
               {s_ready_o, m_valid_o, m_good_o, m_err_o});
    else n_pass++;
    n_checks++;
    if (m_crc_o !== 32'h0) $display("FAIL reset_crc: got %h required 00000000", m_crc_o);
    else n_pass++;
    rst_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (s_ready_o !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", s_ready_o);
    else n_pass++;
  endtask

  task automatic test_check_value();
    int lat;
    f_data = '{32'h3433_3231, 32'h3837_3635, 32'h0000_0039};
    f_keep = '{4'b1111, 4'b1111, 4'b0001};
    send_frame();
    wait_valid(lat);
    n_checks++;
    if (lat !== 2) $display("FAIL check_latency: got %0d required 2", lat);
    else n_pass++;
    n_checks++;
    if (m_crc_o !== 32'hCBF4_3926) $display("FAIL check_crc: got %h required cbf43926", m_crc_o);
    else n_pass++;
    n_checks++;
    if ({m_good_o, m_err_o} !== 2'b00)
      $display("FAIL check_flags: good/err %b required 00", {m_good_o, m_err_o});
    else n_pass++;
    handshake();
    n_checks++;
    if ({m_valid_o, s_ready_o} !== 2'b01)
      $display("FAIL check_after_hs: valid/ready %b required 01", {m_valid_o, s_ready_o});
    else n_pass++;
  endtask

  task automatic test_zero_word();
    int lat;
    f_data = '{32'h0};
    f_keep = '{4'b1111};
    send_frame();
    wait_valid(lat);
    n_checks++;
    if (lat !== 1) $display("FAIL zero_latency: got %0d required 1", lat);
    else n_pass++;
    n_checks++;
    if (m_crc_o !== 32'h2144_DF1C) $display("FAIL zero_crc: got %h required 2144df1c", m_crc_o);
    else n_pass++;
    handshake();
  endtask

  task automatic test_rx_residue();
    int lat;
    f_data = '{32'h3433_3231, 32'h3837_3635, 32'hF439_2639, 32'h0000_00CB};
    f_keep = '{4'b1111, 4'b1111, 4'b1111, 4'b0001};
    send_frame();
    wait_valid(lat);
    n_checks++;
    if (m_good_o !== 1'b1) $display("FAIL rx_good: got %b required 1", m_good_o);
    else n_pass++;
    handshake();
    f_data[1] = f_data[1] ^ 32'h0000_0020;
    send_frame();
    wait_valid(lat);
    n_checks++;
    if (m_good_o !== 1'b0) $display("FAIL rx_bad: got %b required 0", m_good_o);
    else n_pass++;
    handshake();
  endtask

  task automatic test_back_to_back();
    int          lat;
    int          tn;
    logic [31:0] raw;
    logic        err;
    f_data = '{$urandom, $urandom, $urandom};
    f_keep = '{4'b1111, 4'b1111, 4'b1111};
    ref_frame(raw, err, tn);
    send_frame();
    n_checks++;
    if (send_cycles !== 3) $display("FAIL b2b_throughput: got %0d cycles required 3", send_cycles);
    else n_pass++;
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({s_ready_o, m_valid_o} !== 2'b01 || m_crc_o !== (raw ^ 32'hFFFF_FFFF))
        $display("FAIL b2b_hold_%0d: rdy/val %b crc %h required 01 crc %h",
                 c, {s_ready_o, m_valid_o}, m_crc_o, raw ^ 32'hFFFF_FFFF);
      else n_pass++;
      @(negedge clk);
    end
    handshake();
    f_data = '{$urandom, $urandom_range(0, 32'hFFFF)};
    f_keep = '{4'b1111, 4'b0011};
    ref_frame(raw, err, tn);
    send_frame();
    wait_valid(lat);
    n_checks++;
    if (m_crc_o !== (raw ^ 32'hFFFF_FFFF))
      $display("FAIL b2b_second_crc: got %h required %h", m_crc_o, raw ^ 32'hFFFF_FFFF);
    else n_pass++;
    handshake();
  endtask

  task automatic test_protocol_err();
    int          lat;
    int          tn;
    logic [31:0] raw;
    logic        err;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        f_data = '{$urandom, $urandom, $urandom};
        f_keep = '{4'b1111, 4'b0101, 4'b1111};
      end else begin
        f_data = '{$urandom, $urandom};
        f_keep = '{4'b1111, 4'b0000};
      end
      ref_frame(raw, err, tn);
      send_frame();
      wait_valid(lat);
      n_checks++;
      if (m_err_o !== 1'b1 || m_crc_o !== (raw ^ 32'hFFFF_FFFF))
        $display("FAIL proto_err_%0d: err %b crc %h required 1 crc %h",
                 s, m_err_o, m_crc_o, raw ^ 32'hFFFF_FFFF);
      else n_pass++;
      handshake();
      f_data = '{$urandom};
      f_keep = '{4'b1111};
      send_frame();
      wait_valid(lat);
      n_checks++;
      if (m_err_o !== 1'b0) $display("FAIL proto_clear_%0d: err %b required 0", s, m_err_o);
      else n_pass++;
      handshake();
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    int          tn;
    logic        seen;
    logic [31:0] raw;
    logic        err;
    for (int s = 0; s < 2; s++) begin
      f_data = '{$urandom, $urandom};
      f_keep = (s == 0) ? '{4'b1111, 4'b0111} : '{4'b1111, 4'b1111};
      send_frame();
      if (s == 1) wait_valid(lat);
      rst_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({s_ready_o, m_valid_o, m_good_o, m_err_o} !== 4'b0000 || m_crc_o !== 32'h0)
        $display("FAIL rstmid_%0d_outputs: rdy/val/good/err %b crc %h required 0000 crc 0",
                 s, {s_ready_o, m_valid_o, m_good_o, m_err_o}, m_crc_o);
      else n_pass++;
      rst_i = 1'b0;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        seen = seen | m_valid_o;
      end
      n_checks++;
      if (seen !== 1'b0) $display("FAIL rstmid_%0d_no_pulse: saw valid %b required 0", s, seen);
      else n_pass++;
    end
    f_data = '{$urandom, $urandom, 32'($urandom_range(0, 255))};
    f_keep = '{4'b1111, 4'b1111, 4'b0001};
    ref_frame(raw, err, tn);
    send_frame();
    wait_valid(lat);
    n_checks++;
    if (m_crc_o !== (raw ^ 32'hFFFF_FFFF) || m_err_o !== 1'b0)
      $display("FAIL rstmid_next_frame: crc %h err %b required crc %h err 0",
               m_crc_o, m_err_o, raw ^ 32'hFFFF_FFFF);
    else n_pass++;
    handshake();
  endtask

  task automatic test_random();
    int          lat;
    int          tn;
    int          len;
    int          pick;
    logic [31:0] raw;
    logic        err;
    for (int f = 0; f < 24; f++) begin
      len = $urandom_range(1, 5);
      f_data.delete();
      f_keep.delete();
      for (int i = 0; i < len; i++) begin
        f_data.push_back($urandom);
        if (i != len - 1) begin
          f_keep.push_back(($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b1111);
        end else begin
          pick = $urandom_range(0, 8);
          case (pick)
            0, 1:    f_keep.push_back(4'b1111);
            2, 3:    f_keep.push_back(4'b0001);
            4, 5:    f_keep.push_back(4'b0011);
            6, 7:    f_keep.push_back(4'b0111);
            default: f_keep.push_back(4'($urandom));
          endcase
        end
      end
      ref_frame(raw, err, tn);
      send_frame();
      wait_valid(lat);
      n_checks++;
      if (m_valid_o !== 1'b1 || lat !== tn + 1 || m_crc_o !== (raw ^ 32'hFFFF_FFFF) ||
          m_good_o !== (raw == 32'hDEBB_20E3) || m_err_o !== err)
        $display("FAIL rand_%0d: val %b lat %0d crc %h good %b err %b required 1 %0d %h %b %b",
                 f, m_valid_o, lat, m_crc_o, m_good_o, m_err_o,
                 tn + 1, raw ^ 32'hFFFF_FFFF, raw == 32'hDEBB_20E3, err);
      else n_pass++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake();
    end
  endtask

  initial begin
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[i] = c;
    end
    @(negedge clk);
    test_reset();
    test_check_value();
    test_zero_word();
    test_rx_residue();
    test_back_to_back();
    test_protocol_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
